// File: rtl/bf_radix2_inv.sv
`default_nettype none
// ============================================================================
// Module   : bf_radix2_inv
// Purpose  : Pipelined inverse radix-2 DIF butterfly, A/B = (Y0 +/- Y1*conj(W))/2,
//            3-stage valid/ready pipeline with a single global stall enable.
// Revision : 1.0 - initial release
// ============================================================================
module bf_radix2_inv #(
    parameter int DATA_W    = 16,
    parameter int FRAC_BITS = 8,
    parameter int HALVE_EN  = 1
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic [DATA_W-1:0] Y0_re,
    input  logic [DATA_W-1:0] Y0_im,
    input  logic [DATA_W-1:0] Y1_re,
    input  logic [DATA_W-1:0] Y1_im,
    input  logic [DATA_W-1:0] W_re,
    input  logic [DATA_W-1:0] W_im,
    output logic              out_valid,
    input  logic              out_ready,
    output logic [DATA_W-1:0] A_re,
    output logic [DATA_W-1:0] A_im,
    output logic [DATA_W-1:0] B_re,
    output logic [DATA_W-1:0] B_im
);

    localparam int c_PW = 2 * DATA_W;

    logic                     w_en;
    logic                     r_v1, r_v2, r_v3;
    logic signed [DATA_W-1:0] r_y0_re, r_y0_im, r_y1_re, r_y1_im, r_w_re, r_w_im;
    logic signed [DATA_W-1:0] r_p_re, r_p_im, r_z0_re, r_z0_im;
    logic        [DATA_W-1:0] r_a_re, r_a_im, r_b_re, r_b_im;
    logic signed [c_PW-1:0]   w_m_rr, w_m_ii, w_m_ir, w_m_ri;
    logic        [DATA_W-1:0] w_p_re, w_p_im;
    logic        [DATA_W:0]   w_sp_re, w_sp_im, w_sm_re, w_sm_im;
    logic        [DATA_W-1:0] w_a_re, w_a_im, w_b_re, w_b_im;

    // Arithmetic shift floors; bump negative inexact results up to truncate toward zero.
    function automatic logic [DATA_W-1:0] rtz_scale(input logic signed [c_PW-1:0] p);
        logic signed [c_PW-1:0] q;
        q = p >>> FRAC_BITS;
        if (p[c_PW-1] && (p[FRAC_BITS-1:0] != '0))
            q = q + c_PW'(1);
        return q[DATA_W-1:0];
    endfunction

    assign w_en      = ~r_v3 | out_ready;
    assign in_ready  = w_en;
    assign out_valid = r_v3;

    assign w_m_rr = c_PW'(r_y1_re) * c_PW'(r_w_re);
    assign w_m_ii = c_PW'(r_y1_im) * c_PW'(r_w_im);
    assign w_m_ir = c_PW'(r_y1_im) * c_PW'(r_w_re);
    assign w_m_ri = c_PW'(r_y1_re) * c_PW'(r_w_im);

    assign w_p_re = rtz_scale(w_m_rr) + rtz_scale(w_m_ii);
    assign w_p_im = rtz_scale(w_m_ir) - rtz_scale(w_m_ri);

    assign w_sp_re = {r_z0_re[DATA_W-1], r_z0_re} + {r_p_re[DATA_W-1], r_p_re};
    assign w_sp_im = {r_z0_im[DATA_W-1], r_z0_im} + {r_p_im[DATA_W-1], r_p_im};
    assign w_sm_re = {r_z0_re[DATA_W-1], r_z0_re} - {r_p_re[DATA_W-1], r_p_re};
    assign w_sm_im = {r_z0_im[DATA_W-1], r_z0_im} - {r_p_im[DATA_W-1], r_p_im};

    // Halving takes the top DATA_W bits of the 17-bit sum, so it can never overflow.
    assign w_a_re = (HALVE_EN != 0) ? w_sp_re[DATA_W:1] : w_sp_re[DATA_W-1:0];
    assign w_a_im = (HALVE_EN != 0) ? w_sp_im[DATA_W:1] : w_sp_im[DATA_W-1:0];
    assign w_b_re = (HALVE_EN != 0) ? w_sm_re[DATA_W:1] : w_sm_re[DATA_W-1:0];
    assign w_b_im = (HALVE_EN != 0) ? w_sm_im[DATA_W:1] : w_sm_im[DATA_W-1:0];

    // Data registers load only under a valid token so outputs stay put across bubbles.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_v1    <= 1'b0;
            r_v2    <= 1'b0;
            r_v3    <= 1'b0;
            r_y0_re <= '0;
            r_y0_im <= '0;
            r_y1_re <= '0;
            r_y1_im <= '0;
            r_w_re  <= '0;
            r_w_im  <= '0;
            r_p_re  <= '0;
            r_p_im  <= '0;
            r_z0_re <= '0;
            r_z0_im <= '0;
            r_a_re  <= '0;
            r_a_im  <= '0;
            r_b_re  <= '0;
            r_b_im  <= '0;
        end else if (w_en) begin
            r_v1 <= in_valid;
            r_v2 <= r_v1;
            r_v3 <= r_v2;
            if (in_valid) begin
                r_y0_re <= Y0_re;
                r_y0_im <= Y0_im;
                r_y1_re <= Y1_re;
                r_y1_im <= Y1_im;
                r_w_re  <= W_re;
                r_w_im  <= W_im;
            end
            if (r_v1) begin
                r_p_re  <= w_p_re;
                r_p_im  <= w_p_im;
                r_z0_re <= r_y0_re;
                r_z0_im <= r_y0_im;
            end
            if (r_v2) begin
                r_a_re <= w_a_re;
                r_a_im <= w_a_im;
                r_b_re <= w_b_re;
                r_b_im <= w_b_im;
            end
        end
    end

    assign A_re = r_a_re;
    assign A_im = r_a_im;
    assign B_re = r_b_re;
    assign B_im = r_b_im;

endmodule
`default_nettype wire

// File: tb/tb_bf_radix2_inv.sv
`default_nettype none
// ============================================================================
// Module   : tb_bf_radix2_inv
// Purpose  : Self-checking bench for bf_radix2_inv against an integer reference model.
// Revision : 1.0 - initial release
// ============================================================================
module tb_bf_radix2_inv;

    localparam int DW = 16;

    logic          clk = 1'b0;
    logic          rst_n = 1'b0;
    logic          in_valid, in_ready, out_valid, out_ready;
    logic [DW-1:0] y0_re, y0_im, y1_re, y1_im, w_re, w_im;
    logic [DW-1:0] a_re, a_im, b_re, b_im;

    int n_checks = 0;
    int n_errors = 0;

    typedef struct {
        int ar;
        int ai;
        int br;
        int bi;
    } res_t;

    res_t exp_q[$];
    res_t orig_q[$];

    always #5 clk = ~clk;

    bf_radix2_inv #(.DATA_W(DW), .FRAC_BITS(8), .HALVE_EN(1)) dut (
        .clk(clk), .rst_n(rst_n),
        .in_valid(in_valid), .in_ready(in_ready),
        .Y0_re(y0_re), .Y0_im(y0_im), .Y1_re(y1_re), .Y1_im(y1_im),
        .W_re(w_re), .W_im(w_im),
        .out_valid(out_valid), .out_ready(out_ready),
        .A_re(a_re), .A_im(a_im), .B_re(b_re), .B_im(b_im)
    );

    // Signed value of the low DW bits.
    function automatic int sx(input int v);
        logic signed [DW-1:0] t;
        t = v[DW-1:0];
        return int'(t);
    endfunction

    // Reference inverse butterfly: integer division truncates toward zero, >>> floors.
    function automatic res_t model(input logic [DW-1:0] y0r, y0i, y1r, y1i, wr, wi);
        res_t r;
        int pr, pi;
        pr = sx((sx(y1r) * sx(wr)) / 256 + (sx(y1i) * sx(wi)) / 256);
        pi = sx((sx(y1i) * sx(wr)) / 256 - (sx(y1r) * sx(wi)) / 256);
        r.ar = (sx(y0r) + pr) >>> 1;
        r.ai = (sx(y0i) + pi) >>> 1;
        r.br = (sx(y0r) - pr) >>> 1;
        r.bi = (sx(y0i) - pi) >>> 1;
        return r;
    endfunction

    function automatic logic [63:0] pack(input res_t r);
        return {r.ar[15:0], r.ai[15:0], r.br[15:0], r.bi[15:0]};
    endfunction

    function automatic int rnd8(input int x);
        if (x >= 0) return (x + 128) / 256;
        else        return -((-x + 128) / 256);
    endfunction

    function automatic int iabs(input int x);
        return (x < 0) ? -x : x;
    endfunction

    task automatic set_in(input logic v, input logic [DW-1:0] a, b, c, d, e, f);
        in_valid = v;
        y0_re = a; y0_im = b; y1_re = c; y1_im = d; w_re = e; w_im = f;
    endtask

    task automatic test_reset();
        #12;
        n_checks++;
        if (out_valid !== 1'b0 || in_ready !== 1'b1) begin
            n_errors++;
            $display("FAIL reset_hs: out_valid=%b in_ready=%b required 0/1", out_valid, in_ready);
        end
        n_checks++;
        if ({a_re, a_im, b_re, b_im} !== 64'h0) begin
            n_errors++;
            $display("FAIL reset_data: got %h required 0", {a_re, a_im, b_re, b_im});
        end
        @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
    endtask

    // Identity twiddle, -j rotation and round-toward-zero vectors.
    task automatic test_directed();
        logic [DW-1:0] tv[3][6];
        logic [63:0]   ev[3];
        logic [63:0]   got;
        tv = '{'{16'h0200, 16'h0000, 16'h0100, 16'h0000, 16'h0100, 16'h0000},
               '{16'h0000, 16'h0000, 16'h0100, 16'h0000, 16'h0000, 16'hFF00},
               '{16'h0001, 16'h0000, 16'hFFFF, 16'h0000, 16'h0080, 16'h0000}};
        ev = '{64'h0180_0000_0080_0000, 64'h0000_0080_0000_FF80, 64'h0000_0000_0000_0000};
        out_ready = 1'b1;
        for (int i = 0; i < 3; i++) begin
            set_in(1'b1, tv[i][0], tv[i][1], tv[i][2], tv[i][3], tv[i][4], tv[i][5]);
            @(negedge clk);
            in_valid = 1'b0;
            @(negedge clk);
            n_checks++;
            if (out_valid !== 1'b0) begin
                n_errors++;
                $display("FAIL directed%0d_early: out_valid=%b required 0", i, out_valid);
            end
            @(negedge clk);
            got = {a_re, a_im, b_re, b_im};
            n_checks++;
            if (out_valid !== 1'b1 || got !== ev[i]) begin
                n_errors++;
                $display("FAIL directed%0d: valid=%b data=%h required 1/%h", i, out_valid, got, ev[i]);
            end
            @(negedge clk);
            n_checks++;
            if (out_valid !== 1'b0 || {a_re, a_im, b_re, b_im} !== got) begin
                n_errors++;
                $display("FAIL directed%0d_bubble: valid=%b data=%h required 0/%h",
                         i, out_valid, {a_re, a_im, b_re, b_im}, got);
            end
        end
    endtask

    // Five back-to-back inputs with out_ready low in cycles 4..6.
    task automatic test_back_to_back();
        logic [DW-1:0] item[5][6];
        logic [63:0]   prev_out;
        logic [63:0]   got;
        res_t          e;
        bit            stalled_prev;
        int            sent, recv, c;
        for (int i = 0; i < 5; i++)
            for (int j = 0; j < 6; j++)
                item[i][j] = DW'($urandom);
        exp_q.delete();
        sent = 0; recv = 0; c = 0;
        stalled_prev = 1'b0;
        prev_out = '0;
        while (recv < 5 && c < 40) begin
            if (sent < 5) set_in(1'b1, item[sent][0], item[sent][1], item[sent][2],
                                 item[sent][3], item[sent][4], item[sent][5]);
            else          in_valid = 1'b0;
            out_ready = !(c >= 4 && c <= 6);
            #1;
            got = {a_re, a_im, b_re, b_im};
            if (stalled_prev) begin
                n_checks++;
                if (out_valid !== 1'b1 || got !== prev_out) begin
                    n_errors++;
                    $display("FAIL b2b_hold c%0d: valid=%b data=%h required 1/%h", c, out_valid, got, prev_out);
                end
            end
            if (!out_ready && out_valid) begin
                n_checks++;
                if (in_ready !== 1'b0) begin
                    n_errors++;
                    $display("FAIL b2b_in_ready c%0d: got %b required 0", c, in_ready);
                end
            end
            if (out_valid && out_ready) begin
                n_checks++;
                if (exp_q.size() == 0) begin
                    n_errors++;
                    $display("FAIL b2b_extra: unexpected output %h", got);
                end else begin
                    e = exp_q.pop_front();
                    if (got !== pack(e)) begin
                        n_errors++;
                        $display("FAIL b2b_data%0d: got %h required %h", recv, got, pack(e));
                    end
                end
                recv++;
            end
            if (in_valid && in_ready) begin
                exp_q.push_back(model(y0_re, y0_im, y1_re, y1_im, w_re, w_im));
                sent++;
            end
            stalled_prev = out_valid && !out_ready;
            prev_out = got;
            @(negedge clk);
            c++;
        end
        n_checks++;
        if (recv != 5 || sent != 5 || exp_q.size() != 0) begin
            n_errors++;
            $display("FAIL b2b_count: sent %0d recv %0d left %0d required 5/5/0", sent, recv, exp_q.size());
        end
        in_valid = 1'b0;
        out_ready = 1'b1;
    endtask

    // Random A, B, unit-magnitude W through a forward butterfly model and back.
    task automatic test_round_trip();
        int   wt[8][2];
        res_t o, e;
        logic [63:0] got;
        bit   have;
        int   sent, recv, c, dr, di, wi_idx;
        logic [DW-1:0] vy0r, vy0i, vy1r, vy1i, vwr, vwi;
        wt = '{'{256, 0}, '{0, 256}, '{-256, 0}, '{0, -256},
               '{181, 181}, '{181, -181}, '{-181, 181}, '{-181, -181}};
        exp_q.delete();
        orig_q.delete();
        have = 1'b0;
        sent = 0; recv = 0; c = 0;
        vy0r = '0; vy0i = '0; vy1r = '0; vy1i = '0; vwr = '0; vwi = '0;
        o = '{0, 0, 0, 0};
        while (recv < 1000 && c < 20000) begin
            if (!have && sent < 1000) begin
                o.ar = int'($urandom_range(0, 2047)) - 1024;
                o.ai = int'($urandom_range(0, 2047)) - 1024;
                o.br = int'($urandom_range(0, 2047)) - 1024;
                o.bi = int'($urandom_range(0, 2047)) - 1024;
                wi_idx = int'($urandom_range(0, 7));
                dr = o.ar - o.br;
                di = o.ai - o.bi;
                vy0r = DW'(o.ar + o.br);
                vy0i = DW'(o.ai + o.bi);
                vy1r = DW'(rnd8(dr * wt[wi_idx][0] - di * wt[wi_idx][1]));
                vy1i = DW'(rnd8(dr * wt[wi_idx][1] + di * wt[wi_idx][0]));
                vwr  = DW'(wt[wi_idx][0]);
                vwi  = DW'(wt[wi_idx][1]);
                have = 1'b1;
            end
            set_in(have && ($urandom_range(0, 3) != 0), vy0r, vy0i, vy1r, vy1i, vwr, vwi);
            out_ready = ($urandom_range(0, 3) != 0);
            #1;
            n_checks++;
            if (in_ready !== (!out_valid || out_ready)) begin
                n_errors++;
                $display("FAIL rt_in_ready c%0d: got %b required %b", c, in_ready, !out_valid || out_ready);
            end
            if (out_valid && out_ready) begin
                got = {a_re, a_im, b_re, b_im};
                n_checks++;
                if (exp_q.size() == 0) begin
                    n_errors++;
                    $display("FAIL rt_extra: unexpected output %h", got);
                end else begin
                    e = exp_q.pop_front();
                    if (got !== pack(e)) begin
                        n_errors++;
                        $display("FAIL rt_exact%0d: got %h required %h", recv, got, pack(e));
                    end
                    e = orig_q.pop_front();
                    n_checks++;
                    if (iabs(sx(int'(a_re)) - e.ar) > 2 || iabs(sx(int'(a_im)) - e.ai) > 2 ||
                        iabs(sx(int'(b_re)) - e.br) > 2 || iabs(sx(int'(b_im)) - e.bi) > 2) begin
                        n_errors++;
                        $display("FAIL rt_tol%0d: got %h required within 2 LSB of %h",
                                 recv, got, pack(e));
                    end
                end
                recv++;
            end
            if (in_valid && in_ready) begin
                exp_q.push_back(model(y0_re, y0_im, y1_re, y1_im, w_re, w_im));
                orig_q.push_back(o);
                sent++;
                have = 1'b0;
            end
            @(negedge clk);
            c++;
        end
        n_checks++;
        if (recv != 1000) begin
            n_errors++;
            $display("FAIL rt_count: recv %0d required 1000", recv);
        end
        in_valid = 1'b0;
        out_ready = 1'b1;
    endtask

    // Asynchronous reset with three items in flight, then single-item latency.
    task automatic test_reset_midstream();
        res_t e;
        out_ready = 1'b1;
        for (int i = 0; i < 3; i++) begin
            set_in(1'b1, DW'($urandom), DW'($urandom), DW'($urandom),
                   DW'($urandom), DW'($urandom), DW'($urandom));
            if (i < 2) @(negedge clk);
        end
        @(posedge clk);
        in_valid = 1'b0;
        #2;
        n_checks++;
        if (out_valid !== 1'b1) begin
            n_errors++;
            $display("FAIL mid_inflight: out_valid=%b required 1", out_valid);
        end
        rst_n = 1'b0;
        #1;
        n_checks++;
        if (out_valid !== 1'b0 || in_ready !== 1'b1 || {a_re, a_im, b_re, b_im} !== 64'h0) begin
            n_errors++;
            $display("FAIL mid_reset: valid=%b ready=%b data=%h required 0/1/0",
                     out_valid, in_ready, {a_re, a_im, b_re, b_im});
        end
        @(negedge clk);
        rst_n = 1'b1;
        repeat (2) @(negedge clk);
        set_in(1'b1, 16'h0300, 16'hFE00, 16'h0040, 16'hFFC0, 16'h00B5, 16'hFF4B);
        e = model(y0_re, y0_im, y1_re, y1_im, w_re, w_im);
        for (int k = 0; k < 3; k++) begin
            @(negedge clk);
            in_valid = 1'b0;
            n_checks++;
            if (out_valid !== (k == 2)) begin
                n_errors++;
                $display("FAIL mid_latency%0d: out_valid=%b required %b", k, out_valid, k == 2);
            end
        end
        n_checks++;
        if ({a_re, a_im, b_re, b_im} !== pack(e)) begin
            n_errors++;
            $display("FAIL mid_data: got %h required %h", {a_re, a_im, b_re, b_im}, pack(e));
        end
    endtask

    initial begin
        out_ready = 1'b1;
        set_in(1'b0, '0, '0, '0, '0, '0, '0);
        test_reset();
        test_directed();
        test_back_to_back();
        test_round_trip();
        test_reset_midstream();
        $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
        $finish;
    end

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

endmodule
`default_nettype wire
